universal_shift_register: RTL and testbench

Parameterised universal shift register (default 8 bits) with four modes: hold, shift right, shift left, and parallel load. It is a leaf datapath block for serial/parallel conversion and bit-stream alignment. Its registered output feeds downstream logic directly.

---
 rtl/universal_shift_register.sv | 57 +++++
 tb/tb_universal_shift_register.sv | 125 ++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Define USR_ROTATE_EN to make the shift modes rotate instead of taking the serial inputs.
module universal_shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             ser_in_right,
    input  logic             ser_in_left,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] q
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             fill_msb;
    logic             fill_lsb;

`ifdef USR_ROTATE_EN
    logic unused_ser;
    assign unused_ser = ser_in_left ^ ser_in_right;
    assign fill_msb   = q_q[0];
    assign fill_lsb   = q_q[WIDTH-1];
`else
    assign fill_msb   = ser_in_left;
    assign fill_lsb   = ser_in_right;
`endif

    // Unknown mode values fall through to hold.
    always_comb begin
        q_d = q_q;
        case (mode)
            MODE_HOLD: q_d = q_q;
            MODE_SHR:  q_d = {fill_msb, q_q[WIDTH-1:1]};
            MODE_SHL:  q_d = {q_q[WIDTH-2:0], fill_lsb};
            MODE_LOAD: q_d = par_in;
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register (WIDTH = 8).
// Runs the rotate checks instead of the serial-input checks when USR_ROTATE_EN is defined.
module tb_universal_shift_register;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic       ser_in_right;
    logic       ser_in_left;
    logic [7:0] par_in;
    logic [7:0] q;

    int n_checks;
    int n_fail;

    universal_shift_register #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .ser_in_right (ser_in_right),
        .ser_in_left  (ser_in_left),
        .par_in       (par_in),
        .q            (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: q=%h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one operation, clock it, and check q just after the edge.
    task automatic step(input logic [1:0] m, input logic sl, input logic sr,
                        input logic [7:0] p, input logic [7:0] exp, input string tag);
        mode         = m;
        ser_in_left  = sl;
        ser_in_right = sr;
        par_in       = p;
        @(posedge clk);
        #1;
        check(tag, q, exp);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        mode         = 2'b11;
        ser_in_left  = 1'b1;
        ser_in_right = 1'b1;
        par_in       = 8'hFF;
        #1;
        check("reset_async", q, 8'h00);

        for (int i = 0; i < 4; i++) begin
            mode         = 2'($urandom_range(0, 3));
            ser_in_left  = 1'($urandom_range(0, 1));
            ser_in_right = 1'($urandom_range(0, 1));
            par_in       = 8'($urandom_range(1, 255));
            @(posedge clk);
            #1;
            check("reset_hold", q, 8'h00);
        end

        mode  = 2'b00;
        #2;
        rst_n = 1'b1;

`ifdef USR_ROTATE_EN
        step(2'b11, 1'b1, 1'b1, 8'h81, 8'h81, "rot_load");
        step(2'b01, 1'b1, 1'b1, 8'hFF, 8'hC0, "rot_shr1");
        step(2'b01, 1'b1, 1'b1, 8'hFF, 8'h60, "rot_shr2");
        step(2'b10, 1'b1, 1'b1, 8'hFF, 8'hC0, "rot_shl1");
        step(2'b10, 1'b1, 1'b1, 8'hFF, 8'h81, "rot_shl2");
        step(2'b10, 1'b1, 1'b1, 8'hFF, 8'h03, "rot_shl3");
        step(2'b00, 1'b1, 1'b1, 8'hFF, 8'h03, "rot_hold");
`else
        // Unused serial input and par_in are driven opposite/garbage to prove they are ignored.
        step(2'b11, 1'b0, 1'b0, 8'hCC, 8'hCC, "load_cc");
        step(2'b01, 1'b1, 1'b0, 8'h12, 8'hE6, "shr_e6");
        step(2'b01, 1'b1, 1'b0, 8'h34, 8'hF3, "shr_f3");
        step(2'b01, 1'b1, 1'b0, 8'h56, 8'hF9, "shr_f9");
        step(2'b01, 1'b1, 1'b0, 8'h78, 8'hFC, "shr_fc");
        step(2'b10, 1'b1, 1'b0, 8'h9A, 8'hF8, "shl_f8");
        step(2'b10, 1'b1, 1'b0, 8'hBC, 8'hF0, "shl_f0");
        step(2'b10, 1'b1, 1'b0, 8'hDE, 8'hE0, "shl_e0");
        step(2'b10, 1'b1, 1'b0, 8'hFF, 8'hC0, "shl_c0");
        step(2'b00, 1'b1, 1'b1, 8'h00, 8'hC0, "hold_c0_1");
        step(2'b00, 1'b0, 1'b1, 8'h55, 8'hC0, "hold_c0_2");

        step(2'b11, 1'b1, 1'b1, 8'hAA, 8'hAA, "load_aa");
        step(2'b01, 1'b1, 1'b0, 8'h00, 8'hD5, "mix_shr1");
        step(2'b01, 1'b0, 1'b1, 8'hFF, 8'h6A, "mix_shr0");
        step(2'b10, 1'b0, 1'b1, 8'h00, 8'hD5, "mix_shl1");
        step(2'b10, 1'b1, 1'b0, 8'hFF, 8'hAA, "mix_shl0");
        step(2'b00, 1'b1, 1'b1, 8'h00, 8'hAA, "mix_hold");

        step(2'b11, 1'b0, 1'b0, 8'hFF, 8'hFF, "load_ff");
        step(2'b01, 1'b1, 1'b0, 8'h00, 8'hFF, "shr_ff");
        mode = 2'b01;
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_mid_shift", q, 8'h00);
        mode   = 2'b11;
        par_in = 8'hFF;
        @(posedge clk);
        #1;
        check("reset_blocks_load", q, 8'h00);
        #2;
        rst_n = 1'b1;
        step(2'b01, 1'b1, 1'b0, 8'hFF, 8'h80, "resume_shr");
        step(2'b10, 1'b0, 1'b1, 8'h00, 8'h01, "resume_shl");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
